// File: rtl/signal_debouncer_pkg.sv
// Shared types and parameter checks for the signal debouncer.
package signal_debouncer_pkg;

  // Debounce FSM states. The LSB marks "input side is high", the codes are
  // Gray-ordered around the loop LOW -> WAIT_HIGH -> HIGH -> WAIT_LOW.
  typedef enum logic [1:0] {
    S_LOW     = 2'b00,
    WAIT_HIGH = 2'b01,
    S_HIGH    = 2'b11,
    WAIT_LOW  = 2'b10
  } db_state_e;

  // Legal parameter range. A single-flop synchronizer or a one-sample
  // qualification window would defeat the purpose of the block.
  function automatic bit db_params_ok(input int sync_stages, input int db_cycles);
    return (sync_stages >= 2) && (db_cycles >= 2);
  endfunction

endpackage

// File: rtl/signal_debouncer_sync.sv
// Generic N-flop synchronizer with synchronous reset to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage further every clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Chain registers; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/signal_debouncer.sv
// Debouncer: synchronizer followed by a 4-state qualification FSM.
// A level change is accepted only after DB_CYCLES consecutive sampled
// values of the new level; any reversal drops back to the stable state.
module signal_debouncer
  import signal_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic sample_en,
  output logic db_level,
  output logic busy
);

  localparam int CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (!db_params_ok(SYNC_STAGES, DB_CYCLES)) begin : g_bad_params
    $error("signal_debouncer: SYNC_STAGES and DB_CYCLES must both be >= 2");
  end

  logic s_in;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (s_in)
  );

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_level_q, db_level_d;
  logic             busy_q, busy_d;

  // State, counter and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOW;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      busy_q     <= busy_d;
    end
  end

  // Next state: advance only on sampled clocks, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (sample_en) begin
      case (state_q)
        S_LOW:     state_d = s_in ? WAIT_HIGH : S_LOW;
        WAIT_HIGH: if (!s_in)                 state_d = S_LOW;
                   else if (cnt_q == CNT_LAST) state_d = S_HIGH;
        S_HIGH:    state_d = s_in ? S_HIGH : WAIT_LOW;
        WAIT_LOW:  if (s_in)                  state_d = S_HIGH;
                   else if (cnt_q == CNT_LAST) state_d = S_LOW;
        default:   state_d = S_LOW;
      endcase
    end
  end

  // Counter and output updates; the first new-level sample already counts as 1.
  always_comb begin
    cnt_d      = cnt_q;
    db_level_d = db_level_q;
    if (sample_en) begin
      case (state_q)
        S_LOW:  cnt_d = s_in ? CNT_W'(1) : '0;
        WAIT_HIGH: begin
          if (!s_in) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            db_level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_HIGH: cnt_d = s_in ? '0 : CNT_W'(1);
        WAIT_LOW: begin
          if (s_in) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            db_level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d      = '0;
          db_level_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign db_level = db_level_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_signal_debouncer.sv
// Directed bench for signal_debouncer at default parameters
// (SYNC_STAGES=2, DB_CYCLES=4 -> accept on edge 5 after raw_in changes).
module tb_signal_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic raw_in;
  logic sample_en;
  logic db_level;
  logic busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  signal_debouncer #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .sample_en (sample_en),
    .db_level  (db_level),
    .busy      (busy)
  );

  // Advance n rising edges and sample 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; raw_in = 1'b1; sample_en = 1'b1;
    step(3);
    n_total++; if (db_level !== 1'b0) $display("FAIL reset_db_in_rst: got %b want 0", db_level); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy_in_rst: got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    step(1); // edge 0 after release
    n_total++; if (db_level !== 1'b0) $display("FAIL reset_db_release: got %b want 0", db_level); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy_release: got %b want 0", busy); else n_pass++;
    step(4); // edge 4
    n_total++; if (db_level !== 1'b0) $display("FAIL reset_db_e4: got %b want 0", db_level); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL reset_busy_e4: got %b want 1", busy); else n_pass++;
    step(1); // edge 5
    n_total++; if (db_level !== 1'b1) $display("FAIL reset_db_e5: got %b want 1", db_level); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy_e5: got %b want 0", busy); else n_pass++;
    raw_in = 1'b0;
    step(10);
    n_total++; if (db_level !== 1'b0) $display("FAIL reset_db_return_low: got %b want 0", db_level); else n_pass++;
  endtask

  task automatic test_clean_rise;
    raw_in = 1'b1;
    step(2); // edge 1
    n_total++; if (busy !== 1'b0) $display("FAIL rise_busy_e1: got %b want 0", busy); else n_pass++;
    for (int e = 2; e <= 4; e++) begin
      step(1);
      n_total++; if (busy !== 1'b1) $display("FAIL rise_busy_e%0d: got %b want 1", e, busy); else n_pass++;
      n_total++; if (db_level !== 1'b0) $display("FAIL rise_db_e%0d: got %b want 0", e, db_level); else n_pass++;
    end
    step(1); // edge 5
    n_total++; if (db_level !== 1'b1) $display("FAIL rise_db_e5: got %b want 1", db_level); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rise_busy_e5: got %b want 0", busy); else n_pass++;
    // Mirror: clean fall
    raw_in = 1'b0;
    step(2);
    n_total++; if (busy !== 1'b0) $display("FAIL fall_busy_e1: got %b want 0", busy); else n_pass++;
    step(1);
    n_total++; if (busy !== 1'b1) $display("FAIL fall_busy_e2: got %b want 1", busy); else n_pass++;
    step(2);
    n_total++; if (db_level !== 1'b1) $display("FAIL fall_db_e4: got %b want 1", db_level); else n_pass++;
    step(1);
    n_total++; if (db_level !== 1'b0) $display("FAIL fall_db_e5: got %b want 0", db_level); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL fall_busy_e5: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_bounce;
    logic [6:0] pat;
    int bad;
    pat = 7'b0110111; // LSB first: high 3, low 1, high 2, low
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      raw_in = pat[i];
      step(1);
      if (db_level !== 1'b0) bad++;
    end
    raw_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (db_level !== 1'b0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL bounce_low_db: db high on %0d cycles want 0", bad); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL bounce_low_busy: got %b want 0", busy); else n_pass++;
    // Same bounce inverted while held high
    raw_in = 1'b1;
    step(10);
    n_total++; if (db_level !== 1'b1) $display("FAIL bounce_setup_high: got %b want 1", db_level); else n_pass++;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      raw_in = ~pat[i];
      step(1);
      if (db_level !== 1'b1) bad++;
    end
    raw_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (db_level !== 1'b1) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL bounce_high_db: db low on %0d cycles want 0", bad); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL bounce_high_busy: got %b want 0", busy); else n_pass++;
    raw_in = 1'b0;
    step(10);
  endtask

  task automatic test_sample_en;
    // Strobe on edges 3,7,11,15; s_in is high from edge 1, so accept on edge 15.
    raw_in = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      sample_en = ((c % 4) == 3);
      step(1);
      if (c == 2) begin
        n_total++; if (busy !== 1'b0) $display("FAIL sen_busy_c2: got %b want 0", busy); else n_pass++;
      end
      if (c == 3 || c == 10) begin
        n_total++; if (busy !== 1'b1) $display("FAIL sen_busy_c%0d: got %b want 1", c, busy); else n_pass++;
      end
      if (c == 14) begin
        n_total++; if (db_level !== 1'b0) $display("FAIL sen_db_c14: got %b want 0", db_level); else n_pass++;
      end
      if (c == 15) begin
        n_total++; if (db_level !== 1'b1) $display("FAIL sen_db_c15: got %b want 1", db_level); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL sen_busy_c15: got %b want 0", busy); else n_pass++;
      end
    end
    sample_en = 1'b1;
    raw_in = 1'b0;
    step(10);
  endtask

  task automatic test_reset_mid;
    raw_in = 1'b1;
    step(4); // edge 3: WAIT_HIGH, cnt=2
    n_total++; if (busy !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    step(1);
    n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy_after: got %b want 0", busy); else n_pass++;
    n_total++; if (db_level !== 1'b0) $display("FAIL rmid_db_after: got %b want 0", db_level); else n_pass++;
    rst = 1'b0;
    step(5); // edge 4 after release
    n_total++; if (db_level !== 1'b0) $display("FAIL rmid_db_e4: got %b want 0", db_level); else n_pass++;
    step(1);
    n_total++; if (db_level !== 1'b1) $display("FAIL rmid_db_e5: got %b want 1", db_level); else n_pass++;
    // Reset from S_HIGH clears the level immediately
    rst = 1'b1; raw_in = 1'b0;
    step(1);
    n_total++; if (db_level !== 1'b0) $display("FAIL rhigh_db: got %b want 0", db_level); else n_pass++;
    rst = 1'b0;
    step(10);
  endtask

  task automatic test_chain;
    bit seq[$];
    int ticks;
    logic prev;
    seq = '{1, 0, 1, 1, 0, 1};
    for (int i = 0; i < 12; i++) seq.push_back(1'b1);
    seq.push_back(1'b0); seq.push_back(1'b1); seq.push_back(1'b0);
    seq.push_back(1'b0); seq.push_back(1'b1);
    for (int i = 0; i < 12; i++) seq.push_back(1'b0);
    ticks = 0;
    prev  = db_level;
    foreach (seq[i]) begin
      raw_in = seq[i];
      step(1);
      if (db_level !== prev) ticks++;
      prev = db_level;
      if (i == 17) begin
        n_total++; if (db_level !== 1'b1) $display("FAIL chain_pressed: got %b want 1", db_level); else n_pass++;
      end
    end
    n_total++; if (ticks !== 2) $display("FAIL chain_ticks: got %0d want 2", ticks); else n_pass++;
    n_total++; if (db_level !== 1'b0) $display("FAIL chain_released: got %b want 0", db_level); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; raw_in = 1'b0; sample_en = 1'b1;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_sample_en();
    test_reset_mid();
    test_chain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
